// File: rtl/mc_sched_pkg.sv
// rtl/mc_sched_pkg.sv - shared state types and default sizes for the MC job scheduler
package mc_sched_pkg;

  typedef enum logic [1:0] {
    EXP_IDLE = 2'd0,
    EXP_RUN  = 2'd1,
    EXP_FULL = 2'd2
  } exp_state_t;

  typedef enum logic {
    CORE_IDLE = 1'b0,
    CORE_RUN  = 1'b1
  } core_state_t;

  localparam int EXP_MU_N_DEF    = 3;
  localparam int EXP_SIGMA_N_DEF = 3;
  localparam int CORE_N_DEF      = 2;
  localparam int SEL_W_DEF       = 2;

endpackage

// File: rtl/mc_done_collector.sv
// rtl/mc_done_collector.sv - accumulates per-unit done pulses, flags completion and repeats
module mc_done_collector #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_done,
  output logic         o_all,
  output logic         o_dup
);

  logic [W-1:0] r_mask;
  logic [W-1:0] w_done;

  assign w_done = i_en ? i_done : '0;
  // Completion counts bits arriving this cycle so the stage can advance on the next edge.
  assign o_all  = i_en && (&(r_mask | w_done));
  assign o_dup  = |(r_mask & w_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask <= '0;
    end else if (i_clr) begin
      r_mask <= '0;
    end else begin
      r_mask <= r_mask | w_done;
    end
  end

endmodule

// File: rtl/mc_job_scheduler.sv
// rtl/mc_job_scheduler.sv - exp/core stage FSMs with ping-pong table bank for the MC pipeline
module mc_job_scheduler
  import mc_sched_pkg::*;
#(
  parameter int EXP_MU_N    = EXP_MU_N_DEF,
  parameter int EXP_SIGMA_N = EXP_SIGMA_N_DEF,
  parameter int CORE_N      = CORE_N_DEF,
  parameter int SEL_W       = SEL_W_DEF
) (
  input  logic              CLK,
  input  logic              iRstN,
  input  logic              iOptionValid,
  output logic              oOptionAck,
  output logic              oExpStart,
  input  logic              iExpMuDone,
  input  logic              iExpSigmaDone,
  output logic [SEL_W-1:0]  oExpMuSel,
  output logic [SEL_W-1:0]  oExpSigmaSel,
  output logic              oWrBank,
  output logic              oCoreStart,
  input  logic [CORE_N-1:0] iCoreDone,
  output logic              oExpBusy,
  output logic              oCoreBusy,
  output logic              oResultValid,
  output logic              oOverrun
);

  exp_state_t       r_exp_state;
  core_state_t      r_core_state;
  logic             r_pending;
  logic             r_opt_ack;
  logic             r_exp_start;
  logic             r_core_start;
  logic             r_result_valid;
  logic             r_wr_bank;
  logic             r_overrun;
  logic [SEL_W-1:0] r_mu_sel;
  logic [SEL_W-1:0] r_sigma_sel;

  logic             w_exp_run;
  logic             w_core_run;
  logic             w_exp_all;
  logic             w_exp_dup;
  logic             w_core_all;
  logic             w_core_dup;
  logic             w_err;
  logic             w_launch;

  assign w_exp_run  = (r_exp_state == EXP_RUN);
  assign w_core_run = (r_core_state == CORE_RUN);
  assign w_launch   = (r_exp_state == EXP_IDLE) && (r_pending || iOptionValid);

  mc_done_collector #(.W(2)) u_exp_done (
    .i_clk   (CLK),
    .i_rst_n (iRstN),
    .i_en    (w_exp_run),
    .i_clr   (w_exp_all),
    .i_done  ({iExpSigmaDone, iExpMuDone}),
    .o_all   (w_exp_all),
    .o_dup   (w_exp_dup)
  );

  mc_done_collector #(.W(CORE_N)) u_core_done (
    .i_clk   (CLK),
    .i_rst_n (iRstN),
    .i_en    (w_core_run),
    .i_clr   (w_core_all),
    .i_done  (iCoreDone),
    .o_all   (w_core_all),
    .o_dup   (w_core_dup)
  );

  assign w_err = (iOptionValid && r_pending)
               || ((iExpMuDone || iExpSigmaDone) && !w_exp_run)
               || w_exp_dup
               || ((|iCoreDone) && !w_core_run)
               || w_core_dup;

  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      r_exp_state    <= EXP_IDLE;
      r_core_state   <= CORE_IDLE;
      r_pending      <= 1'b0;
      r_opt_ack      <= 1'b0;
      r_exp_start    <= 1'b0;
      r_core_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_wr_bank      <= 1'b0;
      r_overrun      <= 1'b0;
      r_mu_sel       <= '0;
      r_sigma_sel    <= '0;
    end else begin
      r_opt_ack      <= 1'b0;
      r_exp_start    <= 1'b0;
      r_core_start   <= 1'b0;
      r_result_valid <= 1'b0;
      if (w_err) begin
        r_overrun <= 1'b1;
      end

      if (w_launch) begin
        r_pending <= 1'b0;
      end else if (iOptionValid) begin
        r_pending <= 1'b1;
      end

      case (r_exp_state)
        EXP_IDLE: begin
          if (w_launch) begin
            r_exp_state <= EXP_RUN;
            r_exp_start <= 1'b1;
            r_opt_ack   <= 1'b1;
            r_mu_sel    <= '0;
            r_sigma_sel <= '0;
          end
        end
        EXP_RUN: begin
          if (w_exp_all) begin
            r_exp_state <= EXP_FULL;
            r_mu_sel    <= '0;
            r_sigma_sel <= '0;
          end else begin
            r_mu_sel    <= (r_mu_sel == SEL_W'(EXP_MU_N - 1)) ? '0 : r_mu_sel + 1'b1;
            r_sigma_sel <= (r_sigma_sel == SEL_W'(EXP_SIGMA_N - 1)) ? '0 : r_sigma_sel + 1'b1;
          end
        end
        EXP_FULL: begin
          // Hand-off: the finished bank goes to the cores, generators move to the other bank.
          if (r_core_state == CORE_IDLE) begin
            r_exp_state  <= EXP_IDLE;
            r_core_start <= 1'b1;
            r_wr_bank    <= ~r_wr_bank;
          end
        end
        default: begin
          r_exp_state <= EXP_IDLE;
        end
      endcase

      case (r_core_state)
        CORE_IDLE: begin
          if (r_exp_state == EXP_FULL) begin
            r_core_state <= CORE_RUN;
          end
        end
        CORE_RUN: begin
          if (w_core_all) begin
            r_core_state   <= CORE_IDLE;
            r_result_valid <= 1'b1;
          end
        end
        default: begin
          r_core_state <= CORE_IDLE;
        end
      endcase
    end
  end

  assign oOptionAck   = r_opt_ack;
  assign oExpStart    = r_exp_start;
  assign oCoreStart   = r_core_start;
  assign oResultValid = r_result_valid;
  assign oWrBank      = r_wr_bank;
  assign oOverrun     = r_overrun;
  assign oExpMuSel    = r_mu_sel;
  assign oExpSigmaSel = r_sigma_sel;
  assign oExpBusy     = w_exp_run;
  assign oCoreBusy    = w_core_run;

endmodule

// File: tb/tb_mc_job_scheduler.sv
// tb/tb_mc_job_scheduler.sv - directed bench for mc_job_scheduler
module tb_mc_job_scheduler;

  logic       CLK = 1'b0;
  logic       iRstN = 1'b0;
  logic       iOptionValid = 1'b0;
  logic       iExpMuDone = 1'b0;
  logic       iExpSigmaDone = 1'b0;
  logic [1:0] iCoreDone = 2'b00;
  logic       oOptionAck;
  logic       oExpStart;
  logic [1:0] oExpMuSel;
  logic [1:0] oExpSigmaSel;
  logic       oWrBank;
  logic       oCoreStart;
  logic       oExpBusy;
  logic       oCoreBusy;
  logic       oResultValid;
  logic       oOverrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mc_job_scheduler #(
    .EXP_MU_N    (3),
    .EXP_SIGMA_N (3),
    .CORE_N      (2),
    .SEL_W       (2)
  ) dut (
    .CLK           (CLK),
    .iRstN         (iRstN),
    .iOptionValid  (iOptionValid),
    .oOptionAck    (oOptionAck),
    .oExpStart     (oExpStart),
    .iExpMuDone    (iExpMuDone),
    .iExpSigmaDone (iExpSigmaDone),
    .oExpMuSel     (oExpMuSel),
    .oExpSigmaSel  (oExpSigmaSel),
    .oWrBank       (oWrBank),
    .oCoreStart    (oCoreStart),
    .iCoreDone     (iCoreDone),
    .oExpBusy      (oExpBusy),
    .oCoreBusy     (oCoreBusy),
    .oResultValid  (oResultValid),
    .oOverrun      (oOverrun)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    iRstN = 1'b0;
    iOptionValid = 1'b0;
    iExpMuDone = 1'b0;
    iExpSigmaDone = 1'b0;
    iCoreDone = 2'b00;
    repeat (2) @(posedge CLK);
    #1;
    iRstN = 1'b1;
    cyc = 0;
  endtask

  task automatic option_pulse();
    iOptionValid = 1'b1;
    tick();
    iOptionValid = 1'b0;
  endtask

  task automatic exp_dones();
    iExpMuDone = 1'b1;
    iExpSigmaDone = 1'b1;
    tick();
    iExpMuDone = 1'b0;
    iExpSigmaDone = 1'b0;
  endtask

  task automatic core_done(input logic [1:0] bits);
    iCoreDone = bits;
    tick();
    iCoreDone = 2'b00;
  endtask

  logic [1:0] sel_tbl [7];

  initial begin
    sel_tbl = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    // Reset values
    do_reset();
    check("rst_exp_start", 32'(oExpStart), 0);
    check("rst_opt_ack", 32'(oOptionAck), 0);
    check("rst_core_start", 32'(oCoreStart), 0);
    check("rst_result", 32'(oResultValid), 0);
    check("rst_exp_busy", 32'(oExpBusy), 0);
    check("rst_core_busy", 32'(oCoreBusy), 0);
    check("rst_wr_bank", 32'(oWrBank), 0);
    check("rst_mu_sel", 32'(oExpMuSel), 0);
    check("rst_overrun", 32'(oOverrun), 0);

    // Single job
    option_pulse();
    check("job_exp_start", 32'(oExpStart), 1);
    check("job_opt_ack", 32'(oOptionAck), 1);
    check("job_exp_busy", 32'(oExpBusy), 1);
    check("job_mu_sel_first", 32'(oExpMuSel), 0);
    tick();
    check("job_exp_start_pulse", 32'(oExpStart), 0);
    check("job_mu_sel_2", 32'(oExpMuSel), 1);
    run_to(180);
    check("job_mu_sel_180", 32'(oExpMuSel), 2);
    exp_dones();
    check("job_full_busy", 32'(oExpBusy), 0);
    check("job_full_no_start", 32'(oCoreStart), 0);
    tick();
    check("job_core_start", 32'(oCoreStart), 1);
    check("job_wr_bank", 32'(oWrBank), 1);
    check("job_core_busy", 32'(oCoreBusy), 1);
    tick();
    check("job_core_start_pulse", 32'(oCoreStart), 0);
    run_to(700);
    core_done(2'b11);
    check("job_result", 32'(oResultValid), 1);
    check("job_core_idle", 32'(oCoreBusy), 0);
    check("job_exp_idle", 32'(oExpBusy), 0);
    tick();
    check("job_result_pulse", 32'(oResultValid), 0);
    check("job_no_overrun", 32'(oOverrun), 0);

    // Select wrap over a 7-cycle RUN
    do_reset();
    option_pulse();
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("wrap_mu_%0d", k), 32'(oExpMuSel), 32'(sel_tbl[k-1]));
      check($sformatf("wrap_sg_%0d", k), 32'(oExpSigmaSel), 32'(sel_tbl[k-1]));
      if (k == 7) exp_dones();
      else tick();
    end
    check("wrap_full_sel", 32'(oExpMuSel), 0);
    tick();
    check("wrap_held_sel", 32'(oExpMuSel), 0);
    check("wrap_core_start", 32'(oCoreStart), 1);

    // Skewed core completion
    do_reset();
    option_pulse();
    run_to(10);
    exp_dones();
    tick();
    check("skew_core_start", 32'(oCoreStart), 1);
    run_to(500);
    core_done(2'b01);
    check("skew_no_result_501", 32'(oResultValid), 0);
    check("skew_busy_501", 32'(oCoreBusy), 1);
    run_to(520);
    core_done(2'b10);
    check("skew_result_521", 32'(oResultValid), 1);
    tick();
    check("skew_result_pulse", 32'(oResultValid), 0);
    check("skew_no_overrun", 32'(oOverrun), 0);

    // Overlap: second option pends during EXP_FULL, second table waits for cores
    do_reset();
    option_pulse();
    run_to(10);
    exp_dones();
    option_pulse();
    check("ovl_core_start_a", 32'(oCoreStart), 1);
    check("ovl_wr_bank_a", 32'(oWrBank), 1);
    check("ovl_no_exp_start_12", 32'(oExpStart), 0);
    tick();
    check("ovl_exp_start_b", 32'(oExpStart), 1);
    check("ovl_opt_ack_b", 32'(oOptionAck), 1);
    check("ovl_both_busy", 32'({oExpBusy, oCoreBusy}), 3);
    run_to(20);
    exp_dones();
    tick();
    check("ovl_wait_full", 32'(oCoreStart), 0);
    run_to(40);
    core_done(2'b11);
    check("ovl_result_a", 32'(oResultValid), 1);
    check("ovl_no_start_41", 32'(oCoreStart), 0);
    tick();
    check("ovl_core_start_b", 32'(oCoreStart), 1);
    check("ovl_wr_bank_b", 32'(oWrBank), 0);
    run_to(50);
    core_done(2'b11);
    check("ovl_result_b", 32'(oResultValid), 1);
    check("ovl_no_overrun", 32'(oOverrun), 0);

    // Error: mu done while exp idle
    do_reset();
    iExpMuDone = 1'b1;
    tick();
    iExpMuDone = 1'b0;
    check("err_mu_idle", 32'(oOverrun), 1);
    run_to(6);
    check("err_mu_sticky", 32'(oOverrun), 1);
    do_reset();
    check("err_cleared_by_reset", 32'(oOverrun), 0);

    // Error: duplicate core done bit
    option_pulse();
    run_to(5);
    exp_dones();
    tick();
    check("dup_core_start", 32'(oCoreStart), 1);
    core_done(2'b01);
    check("dup_first_ok", 32'(oOverrun), 0);
    core_done(2'b01);
    check("dup_overrun", 32'(oOverrun), 1);

    // Error: double option while pending
    do_reset();
    option_pulse();
    tick();
    option_pulse();
    check("dbl_first_pending_ok", 32'(oOverrun), 0);
    option_pulse();
    check("dbl_overrun", 32'(oOverrun), 1);
    run_to(10);
    check("dbl_sticky", 32'(oOverrun), 1);

    // Reset mid-run with both stages busy
    do_reset();
    option_pulse();
    run_to(5);
    exp_dones();
    tick();
    tick();
    option_pulse();
    tick();
    check("mid_both_busy", 32'({oExpBusy, oCoreBusy}), 3);
    #2;
    iRstN = 1'b0;
    #1;
    check("mid_exp_busy", 32'(oExpBusy), 0);
    check("mid_core_busy", 32'(oCoreBusy), 0);
    check("mid_wr_bank", 32'(oWrBank), 0);
    check("mid_overrun", 32'(oOverrun), 0);
    @(posedge CLK);
    #1;
    iRstN = 1'b1;
    cyc = 0;
    core_done(2'b11);
    check("mid_no_result", 32'(oResultValid), 0);
    check("mid_late_done_overrun", 32'(oOverrun), 1);
    tick();
    check("mid_no_result_later", 32'(oResultValid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
